// File: rtl/keypad_pkg.sv
// keypad_pkg: shared key codes, scan FSM encoding and keypad map helpers
package keypad_pkg;
  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_BS = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hC;
  localparam int MAX_DIGITS = 4;
  localparam logic [63:0] KEY_TABLE = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} scan_state_t;
  function automatic logic [1:0] low_index(input logic [3:0] v);
    return !v[0] ? 2'd0 : !v[1] ? 2'd1 : !v[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    return KEY_TABLE[{r, c, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scan, row synchronizer and press/release debounce for a 4x4 keypad
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  scan_state_t state, state_n;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0] row_meta, row_sync, lat, lat_n, col_n, code_n;
  logic tick, valid_n, last;
  assign tick = div_cnt == DW'(SCAN_DIV - 1);
  assign cnt_inc = cnt + CW'(1);
  assign last = cnt_inc == CW'(DEBOUNCE_CNT);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      div_cnt <= '0;
      state <= SCAN;
      cnt <= '0;
      lat <= 4'hF;
      col <= 4'b1110;
      key_valid <= 1'b0;
      key_code <= 4'h0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      state <= state_n;
      cnt <= cnt_n;
      lat <= lat_n;
      col <= col_n;
      key_valid <= valid_n;
      key_code <= code_n;
    end
  // The column only moves in SCAN, so it doubles as the latched column while debouncing.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    lat_n = lat;
    col_n = col;
    valid_n = 1'b0;
    code_n = key_code;
    if (tick)
      case (state)
        SCAN:
          if (row_sync != 4'hF) begin
            state_n = PRESS_DB;
            lat_n = row_sync;
            cnt_n = '0;
          end else col_n = {col[2:0], col[3]};
        PRESS_DB:
          if (row_sync != lat) state_n = SCAN;
          else if (last) begin
            state_n = HELD;
            valid_n = 1'b1;
            code_n = key_map(low_index(lat), low_index(col));
          end else cnt_n = cnt_inc;
        HELD:
          if (row_sync == 4'hF) begin
            state_n = RELEASE_DB;
            cnt_n = '0;
          end
        RELEASE_DB:
          if (row_sync != 4'hF) state_n = HELD;
          else if (last) state_n = SCAN;
          else cnt_n = cnt_inc;
        default: state_n = SCAN;
      endcase
  end
endmodule

// File: rtl/keypad_entry.sv
// keypad_entry: decimal entry accumulator with clear, backspace and enter over a scanned keypad
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] entry,
  output logic [15:0] value,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        commit
);
  logic [2:0] count;
  logic [16:0] mac;
  logic is_digit;
  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) u_scanner (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .key_valid(key_valid),
    .key_code(key_code)
  );
  assign is_digit = key_code <= 4'd9;
  assign mac = 17'(entry) * 17'd10 + 17'(key_code);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      entry <= '0;
      value <= '0;
      count <= '0;
      commit <= 1'b0;
    end else begin
      commit <= key_valid && key_code == KEY_ENT;
      if (key_valid) begin
        if (is_digit && count < 3'(MAX_DIGITS)) begin
          entry <= mac[15:0];
          count <= count + 3'd1;
        end else if (key_code == KEY_CLR || key_code == KEY_ENT) begin
          entry <= '0;
          count <= '0;
        end else if (key_code == KEY_BS && count != 3'd0) begin
          entry <= entry / 16'd10;
          count <= count - 3'd1;
        end
        if (key_code == KEY_ENT) value <= entry;
      end
    end
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: randomized and directed keypad presses checked against a sample-level model
module tb_keypad_entry;
  localparam int SD = 4;
  localparam int DB = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] row, col, key_code;
  logic [15:0] entry, value;
  logic key_valid, commit;
  logic [3:0] pk_rows = 4'h0;
  int pk_c = 0;
  int n_chk = 0, n_fail = 0, kv_seen = 0, commit_seen = 0;
  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int m_phase, m_col, streak, hi_run, e_entry, e_value;
  bit locked, accepted;
  logic [3:0] lat, s1, s2, e_col, e_code;
  logic e_kv, e_commit;
  int digits[$];
  always #5 clk = ~clk;
  assign row = (pk_rows != 4'h0 && col[pk_c] == 1'b0) ? ~pk_rows : 4'hF;
  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk),
    .reset(reset),
    .row(row),
    .col(col),
    .entry(entry),
    .value(value),
    .key_valid(key_valid),
    .key_code(key_code),
    .commit(commit)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask
  function automatic int low_row(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 3;
  endfunction
  // Model: one decision per sample period, digits kept as a queue of decimal digits.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_col = 0; locked = 0; accepted = 0; streak = 0; hi_run = 0;
      lat = 4'hF; s1 = 4'hF; s2 = 4'hF; digits.delete();
      e_col = 4'hE; e_code = 4'h0; e_kv = 1'b0; e_commit = 1'b0; e_entry = 0; e_value = 0;
    end else begin
      e_commit = 1'b0;
      if (e_kv) begin
        if (e_code <= 4'd9) begin
          if (digits.size() < 4) digits.push_back(int'(e_code));
        end else if (e_code == 4'hA) digits.delete();
        else if (e_code == 4'hB) begin
          if (digits.size() > 0) void'(digits.pop_back());
        end else if (e_code == 4'hC) begin
          e_value = e_entry; e_commit = 1'b1; digits.delete();
        end
        e_entry = 0;
        foreach (digits[i]) e_entry = e_entry * 10 + digits[i];
      end
      e_kv = 1'b0;
      if (m_phase == SD - 1) begin
        if (!locked) begin
          if (s2 != 4'hF) begin locked = 1; accepted = 0; streak = 0; lat = s2; end
          else m_col = (m_col + 1) % 4;
        end else if (!accepted) begin
          if (s2 != lat) locked = 0;
          else begin
            streak++;
            if (streak == DB) begin
              accepted = 1; hi_run = 0; e_kv = 1'b1;
              e_code = 4'(kmap[low_row(lat) * 4 + m_col]);
            end
          end
        end else begin
          hi_run = (s2 == 4'hF) ? hi_run + 1 : 0;
          if (hi_run > DB) locked = 0;
        end
      end
      e_col = ~(4'b1 << m_col);
      s2 = s1; s1 = row;
      m_phase = (m_phase + 1) % SD;
    end
  end
  always @(negedge clk) begin
    chk("col", col, e_col);
    chk("key_valid", key_valid, e_kv);
    chk("key_code", key_code, e_code);
    chk("entry", entry, e_entry);
    chk("value", value, e_value);
    chk("commit", commit, e_commit);
    if (key_valid) kv_seen++;
    if (commit) commit_seen++;
  end
  task automatic press(input logic [3:0] rm, input int c, input int hold, input int gap);
    pk_c = c; pk_rows = rm;
    repeat (hold * SD) @(negedge clk);
    pk_rows = 4'h0;
    repeat (gap * SD) @(negedge clk);
  endtask
  task automatic key(input int code);
    for (int i = 0; i < 16; i++)
      if (kmap[i] == code) begin
        press(4'(1 << (i / 4)), i % 4, 8, 4);
        break;
      end
  endtask
  task automatic key_check(input int code, input int exp_entry);
    key(code);
    #1 chk("entry_literal", entry, exp_entry);
  endtask
  task automatic align_phase0();
    for (int k = 0; k < SD && m_phase != 0; k++) @(negedge clk);
  endtask
  initial begin
    logic [3:0] ec;
    int kb, cb;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1 chk("reset_col", col, 4'b1110);
    for (int k = 1; k <= 8; k++) begin
      repeat (SD) @(negedge clk);
      ec = ~(4'b1 << (k % 4));
      #1 chk("col_sequence", col, ec);
    end
    chk("idle_no_key", kv_seen, 0);
    kb = kv_seen;
    pk_c = 2; pk_rows = 4'b0010;
    repeat (7 * SD) @(negedge clk);
    #1 chk("held_col", col, 4'b1011);
    chk("one_press", kv_seen, kb + 1);
    chk("code6", key_code, 6);
    chk("entry6", entry, 6);
    pk_rows = 4'h0;
    repeat (5 * SD) @(negedge clk);
    chk("no_repeat", kv_seen, kb + 1);
    key_check(10, 0);
    key_check(1, 1);
    key_check(2, 12);
    key_check(3, 123);
    key_check(4, 1234);
    key_check(5, 1234);
    cb = commit_seen;
    key_check(12, 0);
    chk("value1234", value, 1234);
    chk("one_commit", commit_seen, cb + 1);
    key_check(9, 9);
    key_check(8, 98);
    key_check(7, 987);
    key_check(11, 98);
    key_check(10, 0);
    key_check(11, 0);
    kb = kv_seen;
    align_phase0();
    pk_c = m_col; pk_rows = 4'b0100;
    repeat (SD) @(negedge clk);
    pk_rows = 4'h0;
    repeat (4 * SD) @(negedge clk);
    #1 chk("glitch_ignored", kv_seen, kb);
    key_check(4, 4);
    key_check(5, 45);
    align_phase0();
    pk_c = m_col; pk_rows = 4'b0001;
    repeat (SD) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_col", col, 4'b1110);
    chk("rst_entry", entry, 0);
    chk("rst_value", value, 0);
    chk("rst_kv", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_commit", commit, 0);
    pk_rows = 4'h0;
    kb = kv_seen;
    @(negedge clk);
    reset = 1'b1;
    repeat (8 * SD) @(negedge clk);
    chk("rst_no_event", kv_seen, kb);
    for (int n = 0; n < 60; n++) begin
      int pos = $urandom_range(0, 15);
      logic [3:0] rm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << (pos / 4));
      press(rm, pos % 4, $urandom_range(1, 9), $urandom_range(0, 5));
    end
    repeat (6 * SD) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Input-side counterpart to the 4-digit seven-segment display path. Scans a 4x4 matrix keypad by driving columns and reading rows, then debounces each press. Accumulates decimal digit keys into a binary value (0..9999) that feeds the display's 16-bit input. Supports clear, backspace and enter; enter commits the entry to a stable output.

Parameters:
SCAN_DIV, 100000, clk cycles per column step (1 ms at 100 MHz); minimum 2
DEBOUNCE_CNT, 4, consecutive identical row samples required to accept a press or a release; minimum 1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
row  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col  out  4  column drive, active-low, exactly one bit low at all times
entry  out  16  live binary value being typed, 0..9999
value  out  16  last committed binary value, 0..9999, drives the display
key_valid  out  1  one-cycle pulse per accepted key press
key_code  out  4  code of the last accepted key, held until the next press
commit  out  1  one-cycle pulse when value is updated

Behaviour:
- Reset (reset=0, asynchronous) sets: col=4'b1110, state SCAN, entry=0, value=0, digit count=0, key_valid=0, commit=0, key_code=0, and clears the divider and debounce counters.
  - Reset asserted mid-debounce or while a key is held aborts the operation with no event.
- row passes through a 2-FF synchronizer. A "sample" is the synchronized row taken on the last cycle of each SCAN_DIV period.
- Column c (0..3) drives col = ~(1<<c). In SCAN the column advances 0->1->2->3->0 at each period end.
- Key map (row r, col c), listed as codes for row0..row3 left to right:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E(*) 0 F(#) D
- FSM states SCAN, PRESS_DB, HELD, RELEASE_DB:
  - SCAN: if the sample is not 4'b1111, latch the column and the sample, reset the debounce counter and go to PRESS_DB. The column freezes.
  - PRESS_DB: each sample equal to the latched sample increments the counter. A different sample returns to SCAN with no event.
    - When the count reaches DEBOUNCE_CNT: pulse key_valid, load key_code, go to HELD.
  - HELD: a sample of 4'b1111 goes to RELEASE_DB with the counter cleared. No auto-repeat.
  - RELEASE_DB: DEBOUNCE_CNT consecutive all-high samples go to SCAN, where the column resumes advancing at the next period. Any low sample returns to HELD.
- Multiple rows low in one column: the lowest-index low row selects the key code. The latched sample compared during debounce is still the full 4-bit vector.
- Entry logic acts on the edge after key_valid, so entry, value and commit update exactly 1 cycle after key_valid.
  - Digit 0-9 with count<4: entry = entry*10 + d, count++. Use a 17-bit intermediate and truncate to 16 bits; the result never exceeds 9999.
  - Digit with count==4: ignored, entry unchanged.
  - A (clear): entry=0, count=0.
  - B (backspace): entry = entry/10, count-- if count>0; no-op when count==0.
  - C (enter): value<=entry, commit=1 for one cycle, then entry=0 and count=0. Enter with count==0 commits 0.
  - D, E, F: ignored, but key_valid still pulses.
- A leading 0 counts as a digit (count=1, entry=0).
- The entry/value/commit outputs are registered; key_valid, key_code and col are registered.

Decomposition:
- Shared package keypad_pkg holds:
  - key code constants KEY_CLR=4'hA, KEY_BS=4'hB, KEY_ENT=4'hC;
  - the FSM state encoding;
  - the 16-entry row/col-to-code map function;
  - MAX_DIGITS=4.
- One sub-module, keypad_scanner, covers divider, column drive, synchronizer, debounce FSM and key_valid/key_code. Top-level keypad_entry holds the decimal accumulator and commit logic.

Test Plan:
Use SCAN_DIV=4 and DEBOUNCE_CNT=2 throughout.
- Reset release with row=4'hF -> col cycles 1110,1101,1011,0111 every 4 clk; key_valid never pulses.
- Hold row1 low while col2 is active, for 3+ sample periods -> exactly one key_valid with key_code=6; entry=6 one cycle later; col stays 1011 until release plus 2 high samples.
- Press sequence 1,2,3,4,5 then C -> entry goes 1,12,123,1234,1234; value=1234, with commit pulsing one cycle after the C key_valid; entry=0 afterwards.
- Press 9,8,7 then B then A -> entry 9,98,987,98,0; B pressed at count 0 leaves entry=0.
- Glitch: row low for one sample then high -> no key_valid, FSM back to SCAN.
- Assert reset mid-PRESS_DB with entry=45 -> all outputs at reset values immediately; no key_valid after release.
